fir_decim_quant: RTL and testbench
==================================

FIR_DECIM_QUANT -- requirements
Module: fir_decim_quant

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  32  signed FIR filter output sample (outData of FIR_filter).
REQ-005 SHALL have port in_valid  input  1  in_data valid this cycle; there is no upstream backpressure.
REQ-006 SHALL have port shift  input  4  arithmetic right-shift amount, 0..15.
REQ-007 SHALL have port decim  input  3  decimation factor minus one; keep 1 of every decim+1 samples.
REQ-008 SHALL have port out_data  output  16  signed requantised sample at FIFO head.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
REQ-011 SHALL have port sat_flag  output  1  sticky: a kept sample saturated.
REQ-012 SHALL have port ovf_flag  output  1  sticky: a kept sample was dropped because the FIFO was full.

Function
REQ-013 SHALL hold a phase counter that increments on each edge with in_valid=1, and wraps to 0 when counter>=decim; a sample is kept when counter==0 at its accepting edge.
REQ-014 SHALL apply decim changes at the next accepted sample; if the counter exceeds the new decim, the next accepted sample wraps the counter to 0.
REQ-015 SHALL requantise a kept sample as y = (in_data + r) >>> shift, with r per REQ-026/027, using a 33-bit intermediate so the add never overflows.
REQ-016 SHALL saturate y to [-32768, 32767] and set sat_flag when clipping occurs.
REQ-017 SHALL register the requantised value in a stage-1 register at the accepting edge k, and write it into the FIFO at edge k+1.
REQ-018 SHALL assert out_valid in the cycle after edge k+1 when the FIFO was empty, giving a 2-edge latency.
REQ-019 SHALL present FIFO entries in first-in first-out order; out_data shall be the head entry and held stable while out_valid=1 and out_ready=0.
REQ-020 SHALL pop the head on an edge with out_valid=1 and out_ready=1.
REQ-021 SHALL, when the FIFO is full and no pop occurs on that edge, discard the stage-1 write and set ovf_flag.
REQ-022 SHALL, when the FIFO is full and a pop occurs on the same edge, accept the write, leaving occupancy unchanged.
REQ-023 SHALL ignore out_ready when the FIFO is empty; out_data then holds its last value.
REQ-024 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, and derive full and empty from a separate occupancy count.

Reset
REQ-025 SHALL, on an edge with reset=1, clear the phase counter, stage-1 valid, FIFO pointers and occupancy, sat_flag, ovf_flag, out_valid and out_data to 0; reset overrides all simultaneous push and pop activity.

Configuration
REQ-026 SHALL, with macro FIR_DQ_ROUND_EN defined, use r = 1<<(shift-1) for shift>0 and r = 0 for shift=0 (round half up).
REQ-027 SHALL, without FIR_DQ_ROUND_EN, use r = 0 (truncation toward minus infinity); all other behaviour is identical.

Verification
REQ-028 SHALL cover pass-through: reset, shift=0, decim=0, out_ready=1, in_data=100 for one cycle -> out_data=100 with out_valid=1 exactly 2 edges later, for one cycle.
REQ-029 SHALL cover saturation: shift=0, in_data=70000 then -70000 -> out_data=32767 then -32768, sat_flag=1 and remaining 1 until reset.
REQ-030 SHALL cover rounding: shift=4, in_data=24 then -24 -> 2 then -1 with FIR_DQ_ROUND_EN, and 1 then -2 without it.
REQ-031 SHALL cover decimation: decim=3, shift=0, 8 consecutive valid samples 1..8 -> outputs 1 and 5 only, in that order.
REQ-032 SHALL cover overflow: out_ready=0, decim=0, 5 samples 10..14 -> out_valid=1, 10..13 stored, 14 dropped, ovf_flag=1; then out_ready=1 -> 10,11,12,13 on consecutive cycles, then out_valid=0.
REQ-033 SHALL cover reset mid-operation: reset=1 for one edge with 2 entries queued -> next cycle out_valid=0 and both flags 0; the next valid sample is kept (counter=0).

Source files
------------

// File: rtl/fir_decim_quant.sv
// fir_decim_quant: decimates a 32-bit FIR output stream, requantises kept
// samples to 16 bits with saturation, and buffers them in a small output FIFO.
// Optional feature: define FIR_DQ_ROUND_EN for round-half-up requantisation;
// without it the requantiser truncates toward minus infinity.
module fir_decim_quant #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic [3:0]  shift,
  input  logic [2:0]  decim,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sat_flag,
  output logic        ovf_flag
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [2:0]           phase;
  logic                 keep;
  logic [2:0]           phase_next;

  logic [32:0]          rnd;
  logic signed [32:0]   sum;
  logic signed [32:0]   shifted;
  logic [15:0]          quant;
  logic                 clip;

  logic                 s1_valid;
  logic [15:0]          s1_data;

  logic [15:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        rd_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_popped;
  logic [CW-1:0]        count_next;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic [15:0]          head_next;

  // Phase counter decision: keep on phase 0, wrap once the current decim is reached.
  always_comb begin
    keep       = (phase == 3'd0);
    phase_next = (phase >= decim) ? 3'd0 : phase + 3'd1;
  end

  // Requantiser: widen to 33 bits, add rounding offset, shift, then clip to 16 bits.
  always_comb begin
`ifdef FIR_DQ_ROUND_EN
    rnd = (shift != 4'd0) ? (33'd1 << (shift - 4'd1)) : '0;
`else
    rnd = '0;
`endif
    sum     = $signed({in_data[31], in_data}) + $signed(rnd);
    shifted = sum >>> shift;
    clip    = 1'b0;
    quant   = shifted[15:0];
    if (shifted > 33'sd32767) begin
      quant = 16'h7FFF;
      clip  = 1'b1;
    end else if (shifted < -33'sd32768) begin
      quant = 16'h8000;
      clip  = 1'b1;
    end
  end

  // FIFO control: pop on handshake, push stage-1 unless full without a pop.
  // out_data is a register that tracks the head; when the newly written entry
  // becomes the head in the same edge, it is forwarded straight from stage 1.
  always_comb begin
    full         = (count == FULL_COUNT);
    pop          = out_valid && out_ready;
    push         = s1_valid && (!full || pop);
    rd_next      = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_popped = pop ? count - CW'(1) : count;
    count_next   = push ? count_popped + CW'(1) : count_popped;
    head_next    = out_data;
    if (count_next != '0) begin
      head_next = (push && count_popped == '0) ? s1_data : mem[rd_next];
    end
  end

  // State update: phase counter, stage-1 register, FIFO storage and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      s1_valid <= in_valid && keep;
      if (in_valid) begin
        phase <= phase_next;
        if (keep) begin
          s1_data <= quant;
          if (clip) sat_flag <= 1'b1;
        end
      end
      if (push) begin
        mem[wr_ptr] <= s1_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (s1_valid && !push) ovf_flag <= 1'b1;
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_data  <= head_next;
    end
  end

endmodule

// File: tb/tb_fir_decim_quant.sv
// Directed bench for fir_decim_quant: a table of single-sample requantisation
// vectors plus hand-written sequences for decimation, overflow and reset.
module tb_fir_decim_quant;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic [3:0]  shift;
  logic [2:0]  decim;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat_flag;
  logic        ovf_flag;

  int nvec = 0;
  int nerr = 0;
  int got[$];

`ifdef FIR_DQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    int       din;
    logic [3:0] sh;
    int       exp;
    bit       clip;
  } vec_t;

  vec_t tbl[14];

  fir_decim_quant #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .shift     (shift),
    .decim     (decim),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle with optional input sample; records a word that will be popped this edge.
  task automatic cyc(input bit v, input int d);
    in_valid = v;
    in_data  = d;
    if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
    step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
  endtask

  task automatic chk_list(input string name, input int exp[$]);
    chk({name, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    end
  endtask

  initial begin
    bit sat_exp;
    int e[$];

    tbl[0]  = '{100,          4'd0,  100,                  1'b0};
    tbl[1]  = '{70000,        4'd0,  32767,                1'b1};
    tbl[2]  = '{-70000,       4'd0,  -32768,               1'b1};
    tbl[3]  = '{24,           4'd4,  RND ? 2 : 1,          1'b0};
    tbl[4]  = '{-24,          4'd4,  RND ? -1 : -2,        1'b0};
    tbl[5]  = '{-1,           4'd0,  -1,                   1'b0};
    tbl[6]  = '{32767,        4'd0,  32767,                1'b0};
    tbl[7]  = '{32768,        4'd0,  32767,                1'b1};
    tbl[8]  = '{-32768,       4'd0,  -32768,               1'b0};
    tbl[9]  = '{-1001,        4'd3,  RND ? -125 : -126,    1'b0};
    tbl[10] = '{7,            4'd1,  RND ? 4 : 3,          1'b0};
    tbl[11] = '{-5,           4'd2,  RND ? -1 : -2,        1'b0};
    tbl[12] = '{32'h7FFFFFFF, 4'd15, 32767,                1'b1};
    tbl[13] = '{32'h80000000, 4'd15, -32768,               1'b1};

    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    shift = '0; decim = '0; out_ready = 1'b1;
    step();
    do_reset();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset sat_flag", sat_flag, 0);
    chk("reset ovf_flag", ovf_flag, 0);

    // Single-sample vectors: output exactly two edges after acceptance, for one cycle.
    sat_exp = 1'b0;
    for (int i = 0; i < 14; i++) begin
      shift = tbl[i].sh;
      cyc(1'b1, tbl[i].din);
      chk($sformatf("v%0d early valid", i), out_valid, 0);
      cyc(1'b0, 0);
      sat_exp |= tbl[i].clip;
      chk($sformatf("v%0d valid", i), out_valid, 1);
      chk($sformatf("v%0d data", i), int'($signed(out_data)), tbl[i].exp);
      chk($sformatf("v%0d sat", i), sat_flag, int'(sat_exp));
      cyc(1'b0, 0);
      chk($sformatf("v%0d valid drop", i), out_valid, 0);
    end
    chk("ovf after table", ovf_flag, 0);
    got.delete();

    // Decimation by 4: samples 1..8 yield 1 and 5.
    do_reset();
    shift = 4'd0; decim = 3'd3; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) cyc(1'b1, i);
    for (int i = 0; i < 8; i++) cyc(1'b0, 0);
    e = '{1, 5};
    chk_list("decim", e);
    got.delete();

    // Overflow: four stored, fifth dropped, then drained in order.
    do_reset();
    decim = 3'd0; out_ready = 1'b0;
    for (int i = 10; i <= 14; i++) cyc(1'b1, i);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0);
    chk("ovf valid", out_valid, 1);
    chk("ovf head", int'($signed(out_data)), 10);
    chk("ovf flag", ovf_flag, 1);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    chk("ovf head held", int'($signed(out_data)), 10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain valid %0d", i), out_valid, 1);
      chk($sformatf("drain data %0d", i), int'($signed(out_data)), 10 + i);
      step();
    end
    chk("drain empty", out_valid, 0);
    chk("drain hold last", int'($signed(out_data)), 13);

    // Full FIFO with a simultaneous pop accepts the write.
    do_reset();
    got.delete();
    out_ready = 1'b0;
    for (int i = 20; i <= 24; i++) cyc(1'b1, i);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 0);
    e = '{20, 21, 22, 23, 24};
    chk_list("fullpop", e);
    chk("fullpop ovf", ovf_flag, 0);
    got.delete();

    // Reset mid-operation with two queued entries and a non-zero phase.
    do_reset();
    out_ready = 1'b0; decim = 3'd3;
    cyc(1'b1, 70000);
    for (int i = 31; i <= 34; i++) cyc(1'b1, i);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    chk("pre-reset valid", out_valid, 1);
    chk("pre-reset sat", sat_flag, 1);
    do_reset();
    chk("mid reset valid", out_valid, 0);
    chk("mid reset sat", sat_flag, 0);
    chk("mid reset ovf", ovf_flag, 0);
    chk("mid reset data", out_data, 0);
    out_ready = 1'b1;
    cyc(1'b1, 77);
    cyc(1'b0, 0);
    chk("post reset valid", out_valid, 1);
    chk("post reset data", int'($signed(out_data)), 77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
